// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the sequential ALU.
//   - base-op codes carried over unchanged from the combinational ALU
//   - multiply/divide op encodings (md_op_e)
//   - handshake FSM state encoding (state_e)
package alu_seq_pkg;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SLL  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_SLT  = 4'h8;
  localparam logic [3:0] ALU_SLTU = 4'h9;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_muldiv_iter.sv
// muldiv_iter: iterative multiply (shift-add) and restoring divide.
// Operates on operand magnitudes; the sign of the result is restored on the
// final step. One step per cycle, XLEN steps per operation.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   flush_i          abandon the current operation
//   start_i          latch op_i/a_i/b_i and begin
//   op_i, a_i, b_i   operation and operands
//   done_o           high during the cycle whose edge performs the last step
//   result_o         final result, valid while done_o is high
module muldiv_iter
  import alu_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            start_i,
  input  md_op_e          op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [CW-1:0]     cnt_q;
  logic              is_div_q, sel_hi_q, neg_q;
  // Multiply: acc = product, mcand = shifted multiplicand, mplier = multiplier.
  // Divide:   acc low half = remainder, mcand low half = dividend shifting out
  //           while quotient bits shift in, mplier = divisor.
  logic [2*XLEN-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;

  logic              sgn_a, sgn_b, st_div, st_rem;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     rem_sh;
  logic [XLEN-1:0]   rem_nx, raw;
  logic              ge;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    sgn_a  = a_i[XLEN-1] && (op_i inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
    sgn_b  = b_i[XLEN-1] && (op_i inside {MD_MULH, MD_DIV, MD_REM});
    mag_a  = sgn_a ? -a_i : a_i;
    mag_b  = sgn_b ? -b_i : b_i;
    st_div = op_i inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    st_rem = op_i inside {MD_REM, MD_REMU};
  end

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_sh   = {acc_q[XLEN-1:0], mcand_q[XLEN-1]};
    ge       = rem_sh >= {1'b0, mplier_q};
    rem_nx   = ge ? XLEN'(rem_sh - {1'b0, mplier_q}) : rem_sh[XLEN-1:0];
    if (is_div_q) begin
      acc_d   = {{XLEN{1'b0}}, rem_nx};
      mcand_d = {{XLEN{1'b0}}, mcand_q[XLEN-2:0], ge};
    end else begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  // Sign correction works on the post-step values so the result is ready
  // on the same edge as the final step.
  always_comb begin
    prod = neg_q ? -acc_d : acc_d;
    raw  = sel_hi_q ? acc_d[XLEN-1:0] : mcand_d[XLEN-1:0];
    if (is_div_q) result_o = neg_q ? -raw : raw;
    else          result_o = sel_hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
  end

  assign done_o = (cnt_q == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sel_hi_q <= 1'b0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else if (start_i) begin
      cnt_q    <= CW'(XLEN);
      is_div_q <= st_div;
      sel_hi_q <= st_div ? st_rem : (op_i != MD_MUL);
      // Divide by zero keeps the all-ones quotient unnegated; the remainder
      // always takes the dividend's sign.
      neg_q    <= st_div ? (st_rem ? sgn_a : ((sgn_a ^ sgn_b) && (b_i != '0)))
                         : (sgn_a ^ sgn_b);
      acc_q    <= '0;
      mcand_q  <= {{XLEN{1'b0}}, mag_a};
      mplier_q <= mag_b;
    end else if (cnt_q != '0) begin
      cnt_q    <= cnt_q - CW'(1);
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage ALU. Base ops complete in one cycle,
// multiply/divide run iteratively in muldiv_iter.
// Build option: define ALU_SEQ_FAST_MUL_EN for a single-cycle multiplier
// (divide stays iterative).
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   flush                            abort in-flight op, drop pending result
//   in_valid/in_ready                request handshake
//   operand_a, operand_b             operands
//   alu_control                      base op (ALU_* codes)
//   is_muldiv, muldiv_op             multiply/divide select and op
//   out_valid/out_ready              result handshake
//   alu_result, zero                 registered result and zero flag
//
// state  | meaning
// S_IDLE | ready for a request
// S_BUSY | muldiv_iter stepping
// S_DONE | result held until out_ready
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [3:0]      alu_control,
  input  logic            is_muldiv,
  input  logic [2:0]      muldiv_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            zero
);

  localparam int SHW = $clog2(XLEN);

  state_e          state_q;
  logic            in_ready_q, out_valid_q, zero_q;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] base_res, fast_res, next_res, md_result;
  logic [SHW-1:0]  shamt;
  logic            fast_op, md_start, md_done;

  assign shamt = operand_b[SHW-1:0];

  always_comb begin
    case (alu_control)
      ALU_ADD:  base_res = operand_a + operand_b;
      ALU_SUB:  base_res = operand_a - operand_b;
      ALU_AND:  base_res = operand_a & operand_b;
      ALU_OR:   base_res = operand_a | operand_b;
      ALU_XOR:  base_res = operand_a ^ operand_b;
      ALU_SLL:  base_res = operand_a << shamt;
      ALU_SRL:  base_res = operand_a >> shamt;
      ALU_SRA:  base_res = $signed(operand_a) >>> shamt;
      ALU_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
      ALU_SLTU: base_res = {{(XLEN-1){1'b0}}, operand_a < operand_b};
      default:  base_res = '0;
    endcase
  end

`ifdef ALU_SEQ_FAST_MUL_EN
  logic [2*XLEN-1:0] ext_a, ext_b, fast_prod;
  logic              fsa, fsb;
  always_comb begin
    fsa       = operand_a[XLEN-1] && (muldiv_op == MD_MULH || muldiv_op == MD_MULHSU);
    fsb       = operand_b[XLEN-1] && (muldiv_op == MD_MULH);
    // Sign/zero extension to 2*XLEN makes a plain product correct mod 2^(2*XLEN).
    ext_a     = {{XLEN{fsa}}, operand_a};
    ext_b     = {{XLEN{fsb}}, operand_b};
    fast_prod = ext_a * ext_b;
    fast_res  = (muldiv_op == MD_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    fast_op   = is_muldiv && !muldiv_op[2];
  end
`else
  assign fast_res = '0;
  assign fast_op  = 1'b0;
`endif

  assign next_res = fast_op ? fast_res : base_res;
  assign md_start = in_ready_q && in_valid && is_muldiv && !fast_op && !flush;

  muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush_i  (flush),
    .start_i  (md_start),
    .op_i     (md_op_e'(muldiv_op)),
    .a_i      (operand_a),
    .b_i      (operand_b),
    .done_o   (md_done),
    .result_o (md_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
    end else if (flush) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          in_ready_q <= 1'b0;
          if (is_muldiv && !fast_op) begin
            state_q <= S_BUSY;
          end else begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            result_q    <= next_res;
            zero_q      <= (next_res == '0);
          end
        end
        S_BUSY: if (md_done) begin
          state_q     <= S_DONE;
          out_valid_q <= 1'b1;
          result_q    <= md_result;
          zero_q      <= (md_result == '0);
        end
        S_DONE: if (out_ready) begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign alu_result = result_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int XLEN = 32;
`ifdef ALU_SEQ_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic        is_muldiv = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, zero;
  logic [31:0] operand_a = '0, operand_b = '0, alu_result;
  logic [3:0]  alu_control = '0;
  logic [2:0]  muldiv_op = '0;

  int n_vec = 0, n_bad = 0;
  int ready_mode = 0;  // 0: out_ready high, 1: random, 2: held low

  bit          m_have = 1'b0;
  int          m_left = 0;
  logic [31:0] m_res = '0;

  alu_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .operand_a(operand_a), .operand_b(operand_b),
    .alu_control(alu_control), .is_muldiv(is_muldiv), .muldiv_op(muldiv_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %08h required %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %b required %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference semantics from plain integer arithmetic.
  function automatic logic [31:0] ref_op(input logic md, input logic [3:0] ctrl,
                                         input logic [2:0] op,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb;
    if (md) begin
      case (op)
        3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
        3'd1: begin sa = longint'($signed(a)); sb = longint'($signed(b));
                    p = sa * sb; return p[63:32]; end
        3'd2: begin sa = longint'($signed(a)); sb = longint'({32'b0, b});
                    p = sa * sb; return p[63:32]; end
        3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
        3'd4: begin
          if (b == 0) return 32'hFFFF_FFFF;
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
          return $signed(a) / $signed(b);
        end
        3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
        3'd6: begin
          if (b == 0) return a;
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
          return $signed(a) % $signed(b);
        end
        default: return (b == 0) ? a : a % b;
      endcase
    end
    case (ctrl)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction

  // Edges after the accept edge until out_valid is seen.
  function automatic int ref_lat(input logic md, input logic [2:0] op);
    if (!md) return 0;
    if (FAST && !op[2]) return 0;
    return XLEN;
  endfunction

  // Compare process: checks outputs mid-cycle, then advances the model
  // across the coming edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chkb("rst_in_ready", in_ready, 1'b1);
      chkb("rst_out_valid", out_valid, 1'b0);
      chk("rst_result", alu_result, 32'h0);
      chkb("rst_zero", zero, 1'b1);
      m_have = 1'b0;
    end else begin
      chkb("in_ready", in_ready, !m_have);
      chkb("out_valid", out_valid, m_have && m_left == 0);
      if (m_have && m_left == 0) begin
        chk("result", alu_result, m_res);
        chkb("zero", zero, m_res == 0);
      end
      if (flush) m_have = 1'b0;
      else if (!m_have) begin
        if (in_valid) begin
          m_have = 1'b1;
          m_res  = ref_op(is_muldiv, alu_control, muldiv_op, operand_a, operand_b);
          m_left = ref_lat(is_muldiv, muldiv_op);
        end
      end else if (m_left > 0) m_left--;
      else if (out_ready) m_have = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic issue(input logic md, input logic [3:0] ctrl, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    int g;
    @(posedge clk); #1;
    is_muldiv = md; alu_control = ctrl; muldiv_op = op;
    operand_a = a; operand_b = b; in_valid = 1'b1;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!in_ready && g < 500);
    if (g >= 500) chkb("accept_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!(in_ready && !out_valid) && g < 500);
    if (g >= 500) chkb("idle_timeout", in_ready, 1'b1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("pin_add",    ref_op(1'b0, ALU_ADD, 3'd0, 32'd7, 32'd5), 32'd12);
    chk("pin_sll",    ref_op(1'b0, ALU_SLL, 3'd0, 32'd1, 32'd33), 32'd2);
    chk("pin_mulhsu", ref_op(1'b1, 4'd0, 3'd2, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);
    chk("pin_div_ovf", ref_op(1'b1, 4'd0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    chk("pin_rem_ovf", ref_op(1'b1, 4'd0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF), 32'h0);
    chk("pin_divu0",  ref_op(1'b1, 4'd0, 3'd5, 32'd123, 32'd0), 32'hFFFF_FFFF);
    chk("pin_remu0",  ref_op(1'b1, 4'd0, 3'd7, 32'd123, 32'd0), 32'd123);
    chk("pin_unknown", ref_op(1'b0, 4'hF, 3'd0, 32'd9, 32'd9), 32'd0);

    issue(1'b0, ALU_ADD, 3'd0, 32'd7, 32'd5);
    @(negedge clk);
    chk("add_7_5", alu_result, 32'd12);
    chkb("add_zero", zero, 1'b0);
    issue(1'b0, ALU_SUB, 3'd0, 32'd5, 32'd5);
    @(negedge clk);
    chk("sub_5_5", alu_result, 32'd0);
    chkb("sub_zero", zero, 1'b1);

    issue(1'b1, 4'd0, 3'd2, 32'hFFFF_FFFF, 32'd2);  wait_idle();
    issue(1'b1, 4'd0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
    issue(1'b1, 4'd0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
    issue(1'b1, 4'd0, 3'd5, 32'd123, 32'd0);        wait_idle();
    issue(1'b1, 4'd0, 3'd7, 32'd123, 32'd0);        wait_idle();

    // Backpressure on MUL 3*4.
    ready_mode = 2;
    issue(1'b1, 4'd0, 3'd0, 32'd3, 32'd4);
    repeat (XLEN + 10) @(negedge clk);
    chk("bp_result", alu_result, 32'd12);
    chkb("bp_valid", out_valid, 1'b1);
    chkb("bp_in_ready", in_ready, 1'b0);
    ready_mode = 0;
    wait_idle();

    // flush ten cycles into a DIV.
    issue(1'b1, 4'd0, 3'd4, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chkb("flush_in_ready", in_ready, 1'b1);
    chkb("flush_out_valid", out_valid, 1'b0);
    repeat (XLEN) @(negedge clk);

    // flush together with in_valid in IDLE.
    @(posedge clk); #1;
    is_muldiv = 1'b0; alu_control = ALU_ADD; operand_a = 32'd1; operand_b = 32'd1;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chkb("flush_noacc_valid", out_valid, 1'b0);
    chkb("flush_noacc_ready", in_ready, 1'b1);

    // Asynchronous reset mid-MUL.
    issue(1'b1, 4'd0, 3'd0, 32'd9, 32'd9);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chkb("arst_valid", out_valid, 1'b0);
    chk("arst_result", alu_result, 32'h0);
    chkb("arst_zero", zero, 1'b1);
    chkb("arst_in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    issue(1'b0, ALU_SLL, 3'd0, 32'd1, 32'd33);
    @(negedge clk);
    chk("sll_mask", alu_result, 32'd2);

    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            3'($urandom_range(0, 7)), pick(), pick());
      if ($urandom_range(0, 19) == 0) begin
        repeat ($urandom_range(0, 40)) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
      end
    end
    ready_mode = 0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
